// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave front-end for a single-port synchronous 32-bit SRAM.
// Reads issue in the address phase; a read behind a write waits one cycle.
module ahb_sram_ctrl #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  sram_cs,
    output logic [3:0]            sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RD_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_lanes;

    logic                  w_can_accept;
    logic                  w_accept;
    logic                  w_illegal;
    logic [3:0]            w_lanes;
    logic [ADDR_WIDTH-1:0] w_haddr;
    logic                  w_unused;

    assign w_haddr  = HADDR[ADDR_WIDTH+1:2];
    assign w_unused = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    assign w_illegal = HSIZE[2]
                     | (HSIZE == 3'b011)
                     | ((HSIZE == 3'b001) & HADDR[0])
                     | ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00));

    // RD_WAIT and ERR1 hold HREADYOUT low, so no address phase completes there
    assign w_can_accept = (r_state == S_IDLE) | (r_state == S_WRITE)
                        | (r_state == S_READ) | (r_state == S_ERR2);

    assign w_accept = HSEL & HTRANS[1] & HREADY & w_can_accept;

    always_comb begin
        w_lanes = 4'b1111;
        case (HSIZE)
            3'b000:  w_lanes = 4'b0001 << HADDR[1:0];
            3'b001:  w_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
            default: w_lanes = 4'b1111;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_lanes <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept && !w_illegal) begin
                r_addr  <= w_haddr;
                r_lanes <= w_lanes;
            end
        end
    end

    always_comb begin
        w_next     = S_IDLE;
        HREADYOUT  = 1'b1;
        HRESP      = 1'b0;
        HRDATA     = '0;
        sram_cs    = 1'b0;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (!HRESET) begin
            case (r_state)
                S_WRITE: begin
                    sram_cs    = 1'b1;
                    sram_we    = r_lanes;
                    sram_addr  = r_addr;
                    sram_wdata = HWDATA;
                end
                S_READ: HRDATA = sram_rdata;
                S_RD_WAIT: begin
                    sram_cs   = 1'b1;
                    sram_addr = r_addr;
                    HREADYOUT = 1'b0;
                end
                S_ERR1: begin
                    HRESP     = 1'b1;
                    HREADYOUT = 1'b0;
                end
                S_ERR2: HRESP = 1'b1;
                default: ;
            endcase

            if (r_state == S_RD_WAIT) begin
                w_next = S_READ;
            end else if (r_state == S_ERR1) begin
                w_next = S_ERR2;
            end else if (w_accept) begin
                if (w_illegal) begin
                    w_next = S_ERR1;
                end else if (HWRITE) begin
                    w_next = S_WRITE;
                end else if (r_state == S_WRITE) begin
                    // port is busy with the write; read is replayed next cycle
                    w_next = S_RD_WAIT;
                end else begin
                    w_next    = S_READ;
                    sram_cs   = 1'b1;
                    sram_addr = w_haddr;
                end
            end
        end
    end

endmodule
